// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports
// (ALU writeback A, load return B) and a pending-load scoreboard.

module regfile_mp_rd #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREG     = 32,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [NREG-1:0][DATA_W-1:0] regs,
  input  logic [NREG-1:0]             busy,
  input  logic                        wa_ok,
  input  logic [ADDR_W-1:0]           wa_addr,
  input  logic [DATA_W-1:0]           wa_data,
  input  logic                        wb_ok,
  input  logic                        wb_en,
  input  logic [ADDR_W-1:0]           wb_addr,
  input  logic [DATA_W-1:0]           wb_data,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_busy
);
  always_comb begin
    rd_data = regs[rd_addr];
    rd_busy = busy[rd_addr];
    if (BYPASS != 0) begin
      // port A has priority, mirroring the commit order
      if (wa_ok && (wa_addr == rd_addr))      rd_data = wa_data;
      else if (wb_ok && (wb_addr == rd_addr)) rd_data = wb_data;
      if (wb_en && (wb_addr == rd_addr))      rd_busy = 1'b0;
    end
    if ((ZERO_REG != 0) && (rd_addr == '0)) rd_data = '0;
  end
endmodule

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wa_en,
  input  logic [ADDR_W-1:0]          wa_addr,
  input  logic [DATA_W-1:0]          wa_data,
  input  logic                       wb_en,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       sb_set_en,
  input  logic [ADDR_W-1:0]          sb_set_addr,
  output logic [(1<<ADDR_W)-1:0]     busy,
  output logic                       wr_conflict
);
  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NREG-1:0]             busy_q, busy_d;
  logic                        wr_conflict_q, wr_conflict_d;
  logic                        wa_ok, wb_ok, sb_ok;

  // Address 0 is invisible to every update path when hardwired.
  assign wa_ok = wa_en     && !((ZERO_REG != 0) && (wa_addr == '0));
  assign wb_ok = wb_en     && !((ZERO_REG != 0) && (wb_addr == '0));
  assign sb_ok = sb_set_en && !((ZERO_REG != 0) && (sb_set_addr == '0));

  always_comb begin
    regs_d        = regs_q;
    busy_d        = busy_q;
    wr_conflict_d = wa_ok && wb_ok && (wa_addr == wb_addr);
    if (wb_ok) begin
      regs_d[wb_addr] = wb_data;
      busy_d[wb_addr] = 1'b0;
    end
    if (wa_ok) regs_d[wa_addr] = wa_data;
    // a new load issue outranks a stale return to the same register
    if (sb_ok) busy_d[sb_set_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      regs_q        <= '0;
      busy_q        <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign busy        = busy_q;
  assign wr_conflict = wr_conflict_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_mp_rd #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG),
      .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .regs    (regs_q),
      .busy    (busy_q),
      .wa_ok   (wa_ok),
      .wa_addr (wa_addr),
      .wa_data (wa_data),
      .wb_ok   (wb_ok),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .rd_addr (rd_addr[k*ADDR_W +: ADDR_W]),
      .rd_data (rd_data[k*DATA_W +: DATA_W]),
      .rd_busy (rd_busy[k])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a BYPASS=1 instance and a BYPASS=0 instance
// share all inputs; expected values are hand-computed constants.

module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        resetn;
  logic [9:0]  rd_addr;
  logic        wa_en, wb_en, sb_set_en;
  logic [4:0]  wa_addr, wb_addr, sb_set_addr;
  logic [31:0] wa_data, wb_data;

  logic [63:0] rd_data, nb_rd_data;
  logic [1:0]  rd_busy, nb_rd_busy;
  logic [31:0] busy, nb_busy;
  logic        wr_conflict, nb_wr_conflict;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp u_dut (
    .clk(clk), .resetn(resetn), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .busy(busy), .wr_conflict(wr_conflict)
  );

  regfile_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .resetn(resetn), .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .busy(nb_busy), .wr_conflict(nb_wr_conflict)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wa_en = 0; wb_en = 0; sb_set_en = 0;
  endtask

  task automatic edge_settle();
    @(posedge clk); #1;
  endtask

  initial begin
    resetn = 1'b1;
    rd_addr = '0; idle();
    wa_addr = '0; wb_addr = '0; sb_set_addr = '0; wa_data = '0; wb_data = '0;
    #1 resetn = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_conflict", wr_conflict, 0);
    chk("rst_nb_busy", nb_busy, 0);
    @(negedge clk); #2 resetn = 1'b1;

    // every address on both ports reads zero after reset
    for (int a = 0; a < 32; a++) begin
      rd_addr = {a[4:0], a[4:0]};
      #1;
      chk($sformatf("rst_rd_%0d", a), rd_data, 64'h0);
      chk($sformatf("rst_nb_rd_%0d", a), nb_rd_data, 64'h0);
    end
    chk("rst_busy_after", busy, 0);

    // write-after-read on port A, addr 5
    @(negedge clk);
    rd_addr = {5'd0, 5'd5};
    wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF;
    #1;
    chk("byp_wa5", rd_data[31:0], 32'hDEADBEEF);
    chk("nobyp_wa5_old", nb_rd_data[31:0], 32'h0);
    edge_settle(); idle();
    chk("wa5_stored", rd_data[31:0], 32'hDEADBEEF);
    chk("nobyp_wa5_new", nb_rd_data[31:0], 32'hDEADBEEF);

    // conflict: both ports to addr 7, A wins
    @(negedge clk);
    rd_addr = {5'd0, 5'd7};
    wa_en = 1; wa_addr = 7; wa_data = 32'h11111111;
    wb_en = 1; wb_addr = 7; wb_data = 32'h22222222;
    #1;
    chk("byp_conflict_a_over_b", rd_data[31:0], 32'h11111111);
    edge_settle(); idle();
    chk("conflict_pulse", wr_conflict, 1);
    chk("reg7", rd_data[31:0], 32'h11111111);
    chk("nb_reg7", nb_rd_data[31:0], 32'h11111111);
    edge_settle();
    chk("conflict_clear", wr_conflict, 0);

    // same collision on addr 0 is ignored entirely
    @(negedge clk);
    rd_addr = {5'd0, 5'd0};
    wa_en = 1; wa_addr = 0; wa_data = 32'h11111111;
    wb_en = 1; wb_addr = 0; wb_data = 32'h22222222;
    #1;
    chk("byp_reg0", rd_data[31:0], 32'h0);
    edge_settle(); idle();
    chk("conflict_reg0", wr_conflict, 0);
    chk("reg0", rd_data, 64'h0);

    // dual write to different addresses
    @(negedge clk);
    wa_en = 1; wa_addr = 10; wa_data = 32'hAAAA0010;
    wb_en = 1; wb_addr = 11; wb_data = 32'hBBBB0011;
    edge_settle(); idle();
    rd_addr = {5'd11, 5'd10};
    #1;
    chk("dual_write", rd_data, 64'hBBBB0011_AAAA0010);
    chk("dual_no_conflict", wr_conflict, 0);

    // scoreboard: load issue to 9, then return
    @(negedge clk);
    sb_set_en = 1; sb_set_addr = 9;
    edge_settle(); idle();
    rd_addr = {5'd0, 5'd9};
    #1;
    chk("busy9_set", busy, 32'h0000_0200);
    chk("rd_busy9", rd_busy, 2'b01);
    chk("rd9_old", rd_data[31:0], 32'h0);
    @(negedge clk);
    wb_en = 1; wb_addr = 9; wb_data = 32'h12345678;
    #1;
    chk("byp_rd_busy9", rd_busy, 2'b00);
    chk("nobyp_rd_busy9", nb_rd_busy, 2'b01);
    chk("byp_rd9", rd_data[31:0], 32'h12345678);
    chk("nobyp_rd9", nb_rd_data[31:0], 32'h0);
    edge_settle(); idle();
    chk("busy9_clear", busy, 32'h0);
    chk("rd9_new", rd_data[31:0], 32'h12345678);

    // port A write leaves pending bit alone
    @(negedge clk);
    sb_set_en = 1; sb_set_addr = 12;
    edge_settle(); idle();
    @(negedge clk);
    wa_en = 1; wa_addr = 12; wa_data = 32'h0000_0C0C;
    edge_settle(); idle();
    rd_addr = {5'd0, 5'd12};
    #1;
    chk("busy12_kept", busy, 32'h0000_1000);
    chk("rd12_busy_data", {rd_busy, rd_data[31:0]}, {2'b01, 32'h0000_0C0C});

    // set and clear same address: set wins, data updated; sb_set to 0 ignored
    @(negedge clk);
    sb_set_en = 1; sb_set_addr = 3;
    wb_en = 1; wb_addr = 3; wb_data = 32'h33333333;
    edge_settle(); idle();
    rd_addr = {5'd0, 5'd3};
    #1;
    chk("busy3_set_wins", busy, 32'h0000_1008);
    chk("reg3", rd_data[31:0], 32'h33333333);
    @(negedge clk);
    sb_set_en = 1; sb_set_addr = 0;
    edge_settle(); idle();
    chk("busy0_zero", busy, 32'h0000_1008);

    // async reset mid-stream with a conflict pulse live
    @(negedge clk);
    wa_en = 1; wa_addr = 20; wa_data = 32'h1;
    wb_en = 1; wb_addr = 20; wb_data = 32'h2;
    edge_settle(); idle();
    chk("conflict20", wr_conflict, 1);
    #2 resetn = 1'b0;
    rd_addr = {5'd7, 5'd5};
    #1;
    chk("async_busy", busy, 32'h0);
    chk("async_conflict", wr_conflict, 0);
    chk("async_regs", rd_data, 64'h0);
    chk("async_nb_regs", nb_rd_data, 64'h0);

    // updates during reset are dropped; first edge after release commits
    @(negedge clk);
    wa_en = 1; wa_addr = 4; wa_data = 32'h44;
    sb_set_en = 1; sb_set_addr = 4;
    rd_addr = {5'd0, 5'd4};
    edge_settle();
    chk("rst_hold_busy", busy, 32'h0);
    chk("rst_hold_nb_reg4", nb_rd_data[31:0], 32'h0);
    @(negedge clk); resetn = 1'b1;
    edge_settle(); idle();
    chk("post_rst_busy4", busy, 32'h0000_0010);
    chk("post_rst_reg4", rd_data[31:0], 32'h44);

    // late load return after reset still commits data
    @(negedge clk);
    rd_addr = {5'd0, 5'd12};
    wb_en = 1; wb_addr = 12; wb_data = 32'hC0FFEE12;
    edge_settle(); idle();
    chk("late_wb12", rd_data[31:0], 32'hC0FFEE12);
    chk("late_wb12_busy", busy, 32'h0000_0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; NREG = 2**ADDR_W registers.
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, enabling same-cycle write-to-read forwarding.
REQ-005 SHALL have parameter ZERO_REG, default 1, making register 0 hardwired to zero.
REQ-006 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-007 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port rd_addr  input  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-009 SHALL have port rd_data  output  NUM_RD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port rd_busy  output  NUM_RD  per read port, addressed register pending.
REQ-011 SHALL have ports wa_en/wa_addr/wa_data  input  1/ADDR_W/DATA_W  write port A (ALU writeback).
REQ-012 SHALL have ports wb_en/wb_addr/wb_data  input  1/ADDR_W/DATA_W  write port B (load return).
REQ-013 SHALL have ports sb_set_en/sb_set_addr  input  1/ADDR_W  mark register pending (load issue).
REQ-014 SHALL have port busy  output  NREG  registered pending-bit vector.
REQ-015 SHALL have port wr_conflict  output  1  registered one-cycle pulse, both write ports hit same address.

Function
REQ-016 rd_data SHALL be combinational from rd_addr and stored registers, zero latency, all ports independent.
REQ-017 Writes SHALL commit on the rising clk edge; write-after-read same cycle returns old value when BYPASS=0.
REQ-018 Write port A and B SHALL commit in the same cycle to different addresses.
REQ-019 Both ports enabled, same address: port A data SHALL be stored; wr_conflict SHALL be 1 next cycle, else 0.
REQ-020 sb_set_en SHALL set busy[sb_set_addr] at next edge.
REQ-021 wb_en SHALL clear busy[wb_addr] at next edge; port A writes SHALL NOT affect busy.
REQ-022 sb_set_en and wb_en same address same cycle: busy SHALL end set (set wins).
REQ-023 ZERO_REG=1: writes and sb_set to address 0 ignored; reads of address 0 return 0; busy[0] always 0; no wr_conflict for address 0.
REQ-024 BYPASS=1: read address matching an enabled write this cycle SHALL return that write data, port A over port B, except address 0 when ZERO_REG=1.
REQ-025 rd_busy[k] SHALL equal busy[rd_addr k], forced 0 when BYPASS=1 and wb_en with wb_addr equal to that address this cycle.
REQ-026 Busy and data state SHALL be independent: reads of a busy register return stored value with rd_busy=1.

Reset
REQ-027 resetn low SHALL immediately clear all registers, busy vector and wr_conflict to 0, regardless of clk.
REQ-028 Writes or sb_set presented during reset or on the edge reset deasserts SHALL be discarded only while resetn is low; first edge with resetn high commits normally.
REQ-029 Reset asserted mid-operation SHALL drop all pending busy bits; late wb writes after reset commit data normally.

Verification
REQ-030 Reset, then read all NREG addresses on every port -> all 0x00000000, busy=0, wr_conflict=0.
REQ-031 wa write addr 5=0xDEADBEEF, rd_addr0=5 same cycle -> BYPASS=1: 0xDEADBEEF immediately; BYPASS=0: old 0, then 0xDEADBEEF next cycle.
REQ-032 wa and wb both addr 7 (0x11111111 / 0x22222222) -> reg7=0x11111111, wr_conflict=1 one cycle; same to addr 0 -> reg0=0, no conflict.
REQ-033 sb_set addr 9, then read 9 -> rd_busy=1; wb addr 9=0x12345678 -> same cycle rd_busy=0 and data 0x12345678 (BYPASS=1), busy[9]=0 after edge.
REQ-034 sb_set and wb to addr 3 same cycle -> busy[3]=1, reg3 updated; sb_set addr 0 -> busy[0] stays 0.
REQ-035 Pulse resetn low mid-stream with busy bits set and regs written -> all regs and busy 0 immediately, without a clk edge.
